seq_pattern_gen: RTL and testbench

- Serial stimulus source: the transmit end of the single-bit serial input `x` consumed by the lab sequential detectors/state machines.
- Takes a parallel pattern plus a length and repeat count, then drives it MSB-first, one bit per clock, with a valid strobe.
- Inserts a fixed idle gap between repetitions and pulses `done` when finished.
- Exposes its 2-bit state as `A`,`B`, matching the detector-side observation style.

---
 rtl/seq_pattern_gen_pkg.sv | 12 +
 rtl/seq_pattern_gen_if.sv | 30 +++
 rtl/seq_pattern_gen_shifter.sv | 54 +++++
 rtl/seq_pattern_gen.sv | 115 +++++++++++
 tb/tb_seq_pattern_gen.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/seq_pattern_gen_pkg.sv
// rtl/seq_pattern_gen_pkg.sv - state encoding shared by the serial pattern generator
// The encoding is visible on the A/B outputs, so the values are fixed.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SEND = 2'b01,
    ST_GAP  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/seq_pattern_gen_if.sv
// rtl/seq_pattern_gen_if.sv - request and serial-output bundle of seq_pattern_gen
// master drives the request, slave is the generator.
interface seq_pattern_gen_if #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1),
  parameter int RW    = 4
);

  logic             start;
  logic [WIDTH-1:0] pattern_in;
  logic [LW-1:0]    length_in;
  logic [RW-1:0]    repeat_in;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;
  logic             A;
  logic             B;

  modport master (
    output start, pattern_in, length_in, repeat_in,
    input  x, x_valid, busy, done, A, B
  );

  modport slave (
    input  start, pattern_in, length_in, repeat_in,
    output x, x_valid, busy, done, A, B
  );

endinterface

// File: rtl/seq_pattern_gen_shifter.sv
// rtl/seq_pattern_gen_shifter.sv - loadable MSB-first shifter with shadow copy and bit counter
// Parity accumulator exists only with SEQ_PATTERN_GEN_PARITY_EN defined.
module seq_gen_shifter #(
  parameter int WIDTH = 8,
  parameter int LW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             reload,
  input  logic             shift,
  input  logic [WIDTH-1:0] data,
  output logic             msb,
  output logic [LW-1:0]    cnt
`ifdef SEQ_PATTERN_GEN_PARITY_EN
  ,
  output logic             parity
`endif
);

  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shadow;

  assign msb = shreg[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      shreg  <= '0;
      shadow <= '0;
      cnt    <= '0;
    end else if (load) begin
      shreg  <= data;
      shadow <= data;
      cnt    <= '0;
    end else if (reload) begin
      shreg <= shadow;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
      cnt   <= cnt + LW'(1);
    end
  end

`ifdef SEQ_PATTERN_GEN_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset || load || reload) begin
      parity <= 1'b0;
    end else if (shift) begin
      parity <= parity ^ shreg[WIDTH-1];
    end
  end
`endif

endmodule

// File: rtl/seq_pattern_gen.sv
// rtl/seq_pattern_gen.sv - repeating MSB-first serial pattern source with idle gap
// Optional even-parity bit per frame under SEQ_PATTERN_GEN_PARITY_EN.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int LW         = $clog2(WIDTH + 1),
  parameter int RW         = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  seq_pattern_gen_if.slave    bus
);

  localparam int              GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [LW-1:0]   LEN_MAX  = LW'(WIDTH);

  state_t        st;
  logic [LW-1:0] len;
  logic [RW-1:0] reps;
  logic [GW-1:0] gcnt;
  logic          load;
  logic          reload;
  logic          shift;
  logic          msb;
  logic [LW-1:0] cnt;
  logic          frame_end;
  logic          bit_out;

`ifdef SEQ_PATTERN_GEN_PARITY_EN
  logic parity;
  logic par_slot;
  // the parity slot holds the shifter still so the accumulator stays valid
  assign par_slot  = (cnt == len);
  assign frame_end = par_slot;
  assign bit_out   = par_slot ? parity : msb;
  assign shift     = (st == ST_SEND) && !par_slot;
`else
  assign frame_end = (cnt == len - LW'(1));
  assign bit_out   = msb;
  assign shift     = (st == ST_SEND);
`endif

  assign load   = (st == ST_IDLE) && bus.start && (bus.length_in != '0);
  assign reload = ((st == ST_SEND) && frame_end && (reps != '0) && (GAP_CYCLES == 0))
               || ((st == ST_GAP) && (gcnt == GAP_LAST));

  seq_gen_shifter #(.WIDTH(WIDTH), .LW(LW)) u_shifter (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .reload (reload),
    .shift  (shift),
    .data   (bus.pattern_in),
    .msb    (msb),
    .cnt    (cnt)
`ifdef SEQ_PATTERN_GEN_PARITY_EN
    ,
    .parity (parity)
`endif
  );

  // outputs present the state of the previous cycle, so x, x_valid, done and A/B stay aligned
  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= ST_IDLE;
      len         <= '0;
      reps        <= '0;
      gcnt        <= '0;
      bus.x       <= 1'b0;
      bus.x_valid <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.A       <= 1'b0;
      bus.B       <= 1'b0;
    end else begin
      bus.x            <= (st == ST_SEND) & bit_out;
      bus.x_valid      <= (st == ST_SEND);
      bus.busy         <= (st != ST_IDLE);
      bus.done         <= (st == ST_DONE);
      {bus.A, bus.B}   <= st;
      case (st)
        ST_IDLE: begin
          if (load) begin
            len  <= (bus.length_in > LEN_MAX) ? LEN_MAX : bus.length_in;
            reps <= bus.repeat_in;
            st   <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (frame_end) begin
            if (reps != '0) begin
              reps <= reps - RW'(1);
              if (GAP_CYCLES > 0) begin
                gcnt <= '0;
                st   <= ST_GAP;
              end
            end else begin
              st <= ST_DONE;
            end
          end
        end
        ST_GAP: begin
          if (gcnt == GAP_LAST) st <= ST_SEND;
          else                  gcnt <= gcnt + GW'(1);
        end
        ST_DONE: st <= ST_IDLE;
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb/tb_seq_pattern_gen.sv - randomized bench for seq_pattern_gen against a frame-list model
// Honors SEQ_PATTERN_GEN_PARITY_EN to expect the parity bit.
module tb_seq_pattern_gen;

  localparam int WIDTH = 8;
  localparam int LW    = $clog2(WIDTH + 1);
  localparam int RW    = 4;
  localparam int GAP   = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  seq_pattern_gen_if #(.WIDTH(WIDTH), .LW(LW), .RW(RW)) bus ();

  seq_pattern_gen #(.WIDTH(WIDTH), .LW(LW), .RW(RW), .GAP_CYCLES(GAP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       v;
    logic       x;
    logic       d;
    logic [1:0] ab;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // expected observation list: one entry per busy cycle, built from frame rules
  function automatic void build(input logic [WIDTH-1:0] pat, input int len, input int reps);
    int  l;
    logic p;
    exp_q.delete();
    l = (len > WIDTH) ? WIDTH : len;
    for (int r = 0; r <= reps; r++) begin
      p = 1'b0;
      for (int i = 0; i < l; i++) begin
        p = p ^ pat[WIDTH-1-i];
        exp_q.push_back('{v: 1'b1, x: pat[WIDTH-1-i], d: 1'b0, ab: 2'b01});
      end
`ifdef SEQ_PATTERN_GEN_PARITY_EN
      exp_q.push_back('{v: 1'b1, x: p, d: 1'b0, ab: 2'b01});
`endif
      if (r < reps)
        for (int g = 0; g < GAP; g++) exp_q.push_back('{v: 1'b0, x: 1'b0, d: 1'b0, ab: 2'b10});
    end
    exp_q.push_back('{v: 1'b0, x: 1'b0, d: 1'b1, ab: 2'b11});
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_xv"},   32'(bus.x_valid), 32'd0);
    check({tag, "_x"},    32'(bus.x), 32'd0);
    check({tag, "_done"}, 32'(bus.done), 32'd0);
    check({tag, "_ab"},   32'({bus.A, bus.B}), 32'd0);
  endtask

  task automatic drive_req(input logic st, input logic [WIDTH-1:0] pat, input int len, input int reps);
    bus.start      = st;
    bus.pattern_in = pat;
    bus.length_in  = LW'(len);
    bus.repeat_in  = RW'(reps);
  endtask

  // spam re-asserts start with junk while busy; abort_at >= 0 resets after that entry
  task automatic run(input logic [WIDTH-1:0] pat, input int len, input int reps,
                     input bit spam, input int abort_at);
    int n;
    @(negedge clk);
    drive_req(1'b1, pat, len, reps);
    build(pat, len, reps);
    n = exp_q.size();
    @(negedge clk);
    check("launch_busy", 32'(bus.busy), 32'd0);
    drive_req(spam, WIDTH'($urandom), $urandom_range(1, WIDTH), $urandom_range(0, 3));
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("busy", 32'(bus.busy), 32'd1);
      check("xv",   32'(bus.x_valid), 32'(exp_q[i].v));
      check("x",    32'(bus.x), 32'(exp_q[i].x));
      check("done", 32'(bus.done), 32'(exp_q[i].d));
      check("ab",   32'({bus.A, bus.B}), 32'(exp_q[i].ab));
      if (i == abort_at) begin
        reset = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        check_idle("abort");
        reset = 1'b0;
        return;
      end
      drive_req(spam && (i + 1 < n), WIDTH'($urandom), $urandom_range(1, WIDTH), $urandom_range(0, 3));
    end
    @(negedge clk);
    check_idle("after");
  endtask

  initial begin
    drive_req(1'b1, 8'hB6, 8, 0);
    repeat (2) begin
      @(negedge clk);
      check_idle("reset");
    end
    reset = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    run(8'b1011_0110, 8, 0, 1'b0, -1);
    run(8'b0110_0000, 3, 2, 1'b0, -1);

    @(negedge clk);
    drive_req(1'b1, 8'hFF, 0, 1);
    repeat (3) begin
      @(negedge clk);
      check_idle("len0");
    end
    bus.start = 1'b0;

    run(8'hA5, 12, 0, 1'b0, -1);
    run(8'h81, 8, 0, 1'b1, -1);
    run(8'h81, 8, 1, 1'b0, 2);
    run(8'h3C, 6, 1, 1'b0, -1);
    run(8'b1011_0000, 4, 0, 1'b0, -1);
    run(8'h01, 1, 3, 1'b1, -1);

    for (int k = 0; k < 40; k++) begin
      run(WIDTH'($urandom), $urandom_range(1, WIDTH + 3), $urandom_range(0, 3),
          1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
